ysyx_22051086_axi_arbiter: RTL and testbench
============================================

YSYX_22051086_AXI_ARBITER -- requirements
Module: ysyx_22051086_axi_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 64, beat width; BEATS, 4, beats per cache line (line = 256 bits).
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have icache ports: ic_req  in  1; ic_addr  in  32; ic_done  out  1; ic_rdata  out  256.
REQ-004 SHALL have dcache ports: dc_req  in  1; dc_wen  in  1; dc_addr  in  32; dc_wdata  in  256; dc_done  out  1; dc_rdata  out  256; dc_err  out  1.
REQ-005 SHALL have AXI read master ports: araddr  out  32; arlen  out  4; arsize  out  3; arburst  out  2; arvalid  out  1; arready  in  1; rdata  in  64; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.
REQ-006 SHALL have AXI write master ports: awaddr  out  32; awlen  out  4; awsize  out  3; awburst  out  2; awvalid  out  1; awready  in  1; wdata  out  64; wstrb  out  64; wlast  out  1; wvalid  out  1; wready  in  1; bresp  in  2; bvalid  in  1; bready  out  1.

Function
REQ-007 SHALL implement FSM states IDLE, AR, R, AW, W, B, DONE.
REQ-008 IDLE: if dc_req && dc_wen -> AW; else if a read request is pending -> AR; else stay.
REQ-009 Arbitration: when ic_req and dc_req are both pending, grant the client not served last (round-robin); with one pending, grant it; the grant is latched until DONE.
REQ-010 The granted address SHALL be latched with bits [4:0] forced to 0; araddr/awaddr SHALL present this line-aligned address.
REQ-011 Bursts SHALL use arlen/awlen = BEATS-1 (4'd3), arsize/awsize = 3'b011, arburst/awburst = 2'b01 (INCR).
REQ-012 AR: arvalid=1 until arvalid&&arready, then -> R; arvalid SHALL NOT depend combinationally on arready.
REQ-013 R: rready=1; on each rvalid&&rready, beat i (counter 0..3) SHALL be stored at line bits [64*i+63:64*i]; after the beat with rlast=1 or counter==3 -> DONE.
REQ-014 Any rresp != 2'b00 during a burst SHALL set a sticky error flag for that transaction, reported on dc_err at DONE (icache errors ignored); the burst still completes.
REQ-015 AW: awvalid=1 until handshake, then -> W.
REQ-016 W: wvalid=1; wdata = dc_wdata beat selected by counter; wstrb = 64'h00000000000000FF; wlast=1 exactly on counter==3; counter advances only on wvalid&&wready; after the last beat -> B.
REQ-017 B: bready=1; on bvalid&&bready -> DONE; bresp != 0 sets the error flag.
REQ-018 DONE: single-cycle pulse on the granted client's done output (ic_done or dc_done), with ic_rdata/dc_rdata holding the assembled line in that cycle and until the next read completes; -> IDLE.
REQ-019 A client SHALL hold req, addr, wen and wdata stable until its done pulse; it drops req in the cycle after done, and the arbiter SHALL NOT re-grant a request whose done pulse was emitted in the preceding cycle.
REQ-020 Only one AXI transaction SHALL be outstanding; read and write channels are never active simultaneously.
REQ-021 rvalid outside state R and bvalid outside state B SHALL be ignored.

Reset
REQ-022 On rst=0, asynchronously: state=IDLE, beat counter=0, error flag=0, last-grant=icache; arvalid, rready, awvalid, wvalid, wlast, bready, ic_done, dc_done, dc_err=0; line buffer=0.
REQ-023 Reset asserted mid-burst SHALL abandon the transaction with no done pulse; after release, pending requests are re-arbitrated from IDLE.

Structure
REQ-024 Package ysyx_22051086_axi_pkg SHALL hold the state enum, BURST_INCR=2'b01, SIZE_8B=3'b011, RESP_OKAY=2'b00, and LINE_BEATS=4.
REQ-025 One sub-module SHALL be used: ysyx_22051086_line_buf (256-bit beat-indexed assemble/select buffer with counter).

Verification
REQ-026 ic_req, ic_addr=0x8000_0014, slave returns beats 1,2,3,4 -> araddr=0x8000_0000, arlen=3, one ic_done pulse, ic_rdata={64'd4,64'd3,64'd2,64'd1}.
REQ-027 dc_req, dc_wen=1, dc_addr=0x8000_0040, dc_wdata of 4 distinct beats -> awaddr=0x8000_0040, 4 W beats in order, wlast only on the 4th, dc_done after bvalid.
REQ-028 ic_req and dc_req (read) asserted in the same cycle, last grant=icache -> dcache served first, icache immediately after; exactly one done pulse each.
REQ-029 wready held low for 3 cycles on beat 2 -> wdata stable, counter frozen, burst still completes with 4 beats.
REQ-030 rresp=2'b10 on beat 1 of a dcache read -> dc_err=1 with dc_done; rst pulled low mid-R -> all valids 0 immediately, no done, request re-served after release.

Source files
------------

// File: rtl/ysyx_22051086_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051086_axi_pkg
// Description : Shared AXI burst constants and arbiter state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22051086_axi_pkg;

    // Beats in one cache line (4 x 64 bit = 256 bit)
    localparam int         LINE_BEATS = 4;

    // AXI field encodings used by the line-fill / write-back bursts
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Arbiter transaction states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_DONE = 3'd6
    } axi_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22051086_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051086_line_buf
// Description : Beat counter plus 256-bit line buffer. Assembles read beats
//               into the line and selects the current beat of a source line
//               for write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051086_line_buf
    import ysyx_22051086_axi_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BEATS  = LINE_BEATS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        store,
    input  logic                        step,
    input  logic [DATA_W-1:0]           beat_in,
    input  logic [DATA_W*BEATS-1:0]     line_src,
    output logic [$clog2(BEATS)-1:0]    cnt,
    output logic                        cnt_last,
    output logic [DATA_W*BEATS-1:0]     line,
    output logic [DATA_W-1:0]           beat_sel
);

    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W*BEATS-1:0] line_q;

    // Beat counter and line storage; store writes the beat at the current index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clr) begin
            cnt_q  <= '0;
        end else begin
            if (store) begin
                line_q[DATA_W*cnt_q +: DATA_W] <= beat_in;
            end
            if (store || step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cnt      = cnt_q;
    assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));
    assign line     = line_q;
    assign beat_sel = line_src[DATA_W*cnt_q +: DATA_W];

endmodule
`default_nettype wire

// File: rtl/ysyx_22051086_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051086_axi_arbiter
// Description : Round-robin arbiter between icache and dcache onto a single
//               AXI master; one full-line INCR burst outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051086_axi_arbiter
    import ysyx_22051086_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = LINE_BEATS
) (
    input  logic                    clk,
    input  logic                    rst,
    // icache client
    input  logic                    ic_req,
    input  logic [ADDR_W-1:0]       ic_addr,
    output logic                    ic_done,
    output logic [DATA_W*BEATS-1:0] ic_rdata,
    // dcache client
    input  logic                    dc_req,
    input  logic                    dc_wen,
    input  logic [ADDR_W-1:0]       dc_addr,
    input  logic [DATA_W*BEATS-1:0] dc_wdata,
    output logic                    dc_done,
    output logic [DATA_W*BEATS-1:0] dc_rdata,
    output logic                    dc_err,
    // AXI read channels
    output logic [ADDR_W-1:0]       araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    // AXI write channels
    output logic [ADDR_W-1:0]       awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_W-1:0]       wdata,
    output logic [63:0]             wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int                CNT_W      = $clog2(BEATS);
    localparam int                LINE_W     = DATA_W * BEATS;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'h1F);

    axi_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic              grant_dc;
    logic              last_dc;
    logic              is_write;
    logic              err;
    logic              mask_ic;
    logic              mask_dc;
    logic [LINE_W-1:0] rdata_hold;

    logic              ic_elig;
    logic              dc_elig;
    logic              pick_dc;
    logic              buf_clr;
    logic              beat_store;
    logic              beat_step;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_last;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] line_out;

    // Round-robin pick; a client whose done pulse just ended is held off one cycle
    always_comb begin
        ic_elig = ic_req && !mask_ic;
        dc_elig = dc_req && !mask_dc;
        pick_dc = dc_elig && (!ic_elig || !last_dc);
    end

    assign buf_clr    = (state == S_IDLE);
    assign beat_store = (state == S_R) && rvalid && rready;
    assign beat_step  = (state == S_W) && wvalid && wready;

    ysyx_22051086_line_buf #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_line_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (buf_clr),
        .store    (beat_store),
        .step     (beat_step),
        .beat_in  (rdata),
        .line_src (dc_wdata),
        .cnt      (cnt),
        .cnt_last (cnt_last),
        .line     (line),
        .beat_sel (wdata)
    );

    // Transaction FSM with all handshake and completion outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            grant_dc   <= 1'b0;
            last_dc    <= 1'b0;
            is_write   <= 1'b0;
            err        <= 1'b0;
            mask_ic    <= 1'b0;
            mask_dc    <= 1'b0;
            rdata_hold <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            wlast      <= 1'b0;
            bready     <= 1'b0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
            dc_err     <= 1'b0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            dc_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    mask_ic <= 1'b0;
                    mask_dc <= 1'b0;
                    if (ic_elig || dc_elig) begin
                        grant_dc <= pick_dc;
                        last_dc  <= pick_dc;
                        addr_q   <= (pick_dc ? dc_addr : ic_addr) & ALIGN_MASK;
                        err      <= 1'b0;
                        if (pick_dc && dc_wen) begin
                            is_write <= 1'b1;
                            awvalid  <= 1'b1;
                            state    <= S_AW;
                        end else begin
                            is_write <= 1'b0;
                            arvalid  <= 1'b1;
                            state    <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid && rready) begin
                        if (rresp != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        if (rlast || cnt_last) begin
                            rready  <= 1'b0;
                            ic_done <= !grant_dc;
                            dc_done <= grant_dc;
                            dc_err  <= grant_dc && (err || (rresp != RESP_OKAY));
                            state   <= S_DONE;
                        end
                    end
                end
                S_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= 1'b0;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (wvalid && wready) begin
                        if (cnt_last) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= S_B;
                        end else begin
                            // The beat after this one is the final one
                            wlast <= (cnt == CNT_W'(BEATS - 2));
                        end
                    end
                end
                S_B: begin
                    if (bvalid && bready) begin
                        if (bresp != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        bready  <= 1'b0;
                        ic_done <= !grant_dc;
                        dc_done <= grant_dc;
                        dc_err  <= grant_dc && (err || (bresp != RESP_OKAY));
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    mask_ic <= !grant_dc;
                    mask_dc <= grant_dc;
                    if (!is_write) begin
                        rdata_hold <= line;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The freshly assembled line is visible in the done cycle, then held
    assign line_out = ((state == S_DONE) && !is_write) ? line : rdata_hold;
    assign ic_rdata = line_out;
    assign dc_rdata = line_out;

    assign araddr  = addr_q;
    assign arlen   = 4'(BEATS - 1);
    assign arsize  = SIZE_8B;
    assign arburst = BURST_INCR;
    assign awaddr  = addr_q;
    assign awlen   = 4'(BEATS - 1);
    assign awsize  = SIZE_8B;
    assign awburst = BURST_INCR;
    assign wstrb   = 64'h00000000000000FF;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051086_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051086_axi_arbiter
// Description : Directed self-checking bench for the icache/dcache AXI arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051086_axi_arbiter;

    logic         clk;
    logic         rst;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_done;
    logic [255:0] ic_rdata;
    logic         dc_req;
    logic         dc_wen;
    logic [31:0]  dc_addr;
    logic [255:0] dc_wdata;
    logic         dc_done;
    logic [255:0] dc_rdata;
    logic         dc_err;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [63:0]  wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22051086_axi_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_done  (ic_done),
        .ic_rdata (ic_rdata),
        .dc_req   (dc_req),
        .dc_wen   (dc_wen),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_done  (dc_done),
        .dc_rdata (dc_rdata),
        .dc_err   (dc_err),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ar();
        int n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("arvalid_wait", arvalid, 1'b1);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (awvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("awvalid_wait", awvalid, 1'b1);
    endtask

    // Entered with arvalid high; ends on the negedge of the done cycle
    task automatic serve_read(input logic [255:0] ln, input int bad_idx, input bit stray);
        if (stray) begin
            rvalid = 1'b1; rdata = 64'hDEADDEADDEADDEAD; rresp = 2'b10; rlast = 1'b1;
            @(negedge clk);
            rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
            check_val("ar_hold", arvalid, 1'b1);
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check_val("r_enter", {arvalid, rready}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1;
            rdata  = ln[64*i +: 64];
            rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
            rlast  = (i == 3);
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
    endtask

    // Done pulse must end, and the served request (still high) not re-granted
    task automatic post_done();
        @(negedge clk);
        check_val("done_end", {ic_done, dc_done}, 2'b00);
        @(negedge clk);
        check_val("no_regrant", {arvalid, awvalid}, 2'b00);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] wd, input int stall_idx,
                            input logic [1:0] bresp_v, input logic exp_err);
        dc_req = 1'b1; dc_wen = 1'b1; dc_addr = addr; dc_wdata = wd;
        wait_aw();
        check_val("awaddr", awaddr, exp_addr);
        check_val("aw_fmt", {awlen, awsize, awburst}, {4'd3, 3'b011, 2'b01});
        check_val("ar_quiet", arvalid, 1'b0);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check_val("w_enter", {awvalid, wvalid}, 2'b01);
        check_val("wstrb", wstrb, 64'hFF);
        for (int i = 0; i < 4; i++) begin
            check_val("wdata", wdata, wd[64*i +: 64]);
            check_val("wlast", wlast, (i == 3));
            if (i == stall_idx) begin
                bvalid = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_val("wdata_stall", wdata, wd[64*i +: 64]);
                    check_val("wvalid_stall", {wvalid, wlast}, {1'b1, (i == 3)});
                end
                bvalid = 1'b0;
            end
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        check_val("b_enter", {wvalid, wlast, bready}, 3'b001);
        bvalid = 1'b1; bresp = bresp_v;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        check_val("dc_done_w", {ic_done, dc_done, dc_err}, {1'b0, 1'b1, exp_err});
        post_done();
        dc_req = 1'b0; dc_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("reset_outs",
                  {arvalid, rready, awvalid, wvalid, wlast, bready, ic_done, dc_done, dc_err},
                  9'b0);
        check_val("reset_line", ic_rdata, 256'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic [255:0] l1;
        logic [255:0] ld;
        logic [255:0] li;
        logic [255:0] le;
        logic [255:0] lr;
        l1 = {64'd4, 64'd3, 64'd2, 64'd1};
        ld = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
              64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        li = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
              64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001};
        le = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        lr = {64'hAA04, 64'hAA03, 64'hAA02, 64'hAA01};

        rst = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_wen = 1'b0; dc_addr = '0; dc_wdata = '0;
        arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        @(negedge clk);
        do_reset();

        // icache line fill with unaligned address
        ic_req = 1'b1; ic_addr = 32'h8000_0014;
        wait_ar();
        check_val("araddr_ic", araddr, 32'h8000_0000);
        check_val("ar_fmt", {arlen, arsize, arburst}, {4'd3, 3'b011, 2'b01});
        check_val("rready_in_ar", rready, 1'b0);
        serve_read(l1, 9, 1'b0);
        check_val("ic_done_1", {ic_done, dc_done}, 2'b10);
        check_val("ic_rdata_1", ic_rdata, l1);
        post_done();
        check_val("ic_rdata_hold", ic_rdata, l1);
        ic_req = 1'b0;

        // dcache write-back, no stall, then with a 3-cycle stall on beat 2 and bad bresp
        do_write(32'h8000_0040, 32'h8000_0040, ld, 9, 2'b00, 1'b0);
        do_write(32'h8000_0085, 32'h8000_0080, li, 2, 2'b10, 1'b1);

        // simultaneous reads after reset (last grant icache): dcache first
        do_reset();
        ic_req = 1'b1; ic_addr = 32'h8000_0100;
        dc_req = 1'b1; dc_wen = 1'b0; dc_addr = 32'h8000_0223;
        wait_ar();
        check_val("araddr_dc_first", araddr, 32'h8000_0220);
        serve_read(ld, 9, 1'b1);
        check_val("dc_done_rr", {ic_done, dc_done, dc_err}, 3'b010);
        check_val("dc_rdata_rr", dc_rdata, ld);
        @(negedge clk);
        check_val("dc_done_end", {ic_done, dc_done}, 2'b00);
        @(negedge clk);
        check_val("ic_next", {arvalid, araddr}, {1'b1, 32'h8000_0100});
        dc_req = 1'b0;
        serve_read(li, 9, 1'b0);
        check_val("ic_done_rr", {ic_done, dc_done}, 2'b10);
        check_val("ic_rdata_rr", ic_rdata, li);
        post_done();
        ic_req = 1'b0;

        // dcache read with error response on beat 1
        dc_req = 1'b1; dc_wen = 1'b0; dc_addr = 32'h8000_0300;
        wait_ar();
        check_val("araddr_err", araddr, 32'h8000_0300);
        serve_read(le, 1, 1'b0);
        check_val("dc_err_done", {ic_done, dc_done, dc_err}, 3'b011);
        check_val("dc_rdata_err", dc_rdata, le);
        post_done();
        dc_req = 1'b0;

        // reset mid-R: abandon, then re-serve after release
        ic_req = 1'b1; ic_addr = 32'h8000_0410;
        wait_ar();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1; rdata = 64'hBAD0 + 64'(i); rlast = 1'b0;
            @(negedge clk);
        end
        rvalid = 1'b0;
        rst = 1'b0;
        #1;
        check_val("async_rst", {arvalid, rready, awvalid, wvalid, bready, ic_done, dc_done}, 7'b0);
        @(negedge clk);
        check_val("rst_no_done", {ic_done, dc_done}, 2'b00);
        rst = 1'b1;
        wait_ar();
        check_val("araddr_reserve", araddr, 32'h8000_0400);
        serve_read(lr, 2, 1'b0);
        check_val("ic_done_reserve", {ic_done, dc_done, dc_err}, 3'b100);
        check_val("ic_rdata_reserve", ic_rdata, lr);
        post_done();
        ic_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
